// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan driver: glyph table, BCD sizing
// and the converter state encoding.
package seg7_pkg;

  localparam int NUM_DIGITS = 8;
  localparam int BCD_W      = 32;
  localparam int MAX_VAL    = 99_999_999;

  // Glyphs are active-high {g,f,e,d,c,b,a}; output polarity is applied at the pins.
  localparam logic [6:0] GLYPH_0     = 7'b0111111;
  localparam logic [6:0] GLYPH_1     = 7'b0000110;
  localparam logic [6:0] GLYPH_2     = 7'b1011011;
  localparam logic [6:0] GLYPH_3     = 7'b1001111;
  localparam logic [6:0] GLYPH_4     = 7'b1100110;
  localparam logic [6:0] GLYPH_5     = 7'b1101101;
  localparam logic [6:0] GLYPH_6     = 7'b1111101;
  localparam logic [6:0] GLYPH_7     = 7'b0000111;
  localparam logic [6:0] GLYPH_8     = 7'b1111111;
  localparam logic [6:0] GLYPH_9     = 7'b1101111;
  localparam logic [6:0] GLYPH_DASH  = 7'b1000000;
  localparam logic [6:0] GLYPH_BLANK = 7'b0000000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } conv_state_t;

  function automatic logic [6:0] glyph(input logic [3:0] nib);
    case (nib)
      4'd0:    glyph = GLYPH_0;
      4'd1:    glyph = GLYPH_1;
      4'd2:    glyph = GLYPH_2;
      4'd3:    glyph = GLYPH_3;
      4'd4:    glyph = GLYPH_4;
      4'd5:    glyph = GLYPH_5;
      4'd6:    glyph = GLYPH_6;
      4'd7:    glyph = GLYPH_7;
      4'd8:    glyph = GLYPH_8;
      4'd9:    glyph = GLYPH_9;
      default: glyph = GLYPH_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one shift/adjust iteration per cycle,
// out-of-range inputs bypass the shift phase and flag overflow.
module bin2bcd_seq
  import seg7_pkg::*;
#(
  parameter int BIN_W = 27
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [BIN_W-1:0] value,
  output logic             busy,
  output logic             done,
  output logic             overflow,
  output logic [BCD_W-1:0] bcd
);

  localparam int CNT_W = $clog2(BIN_W + 1);

  conv_state_t      state;
  logic [BIN_W-1:0] bin_sr;
  logic [BCD_W-1:0] bcd_acc;
  logic [BCD_W-1:0] bcd_adj;
  logic [CNT_W-1:0] cnt;
  logic             ovf_reg;

  genvar gi;
  generate
    for (gi = 0; gi < BCD_W / 4; gi++) begin : g_adj
      assign bcd_adj[4*gi +: 4] = (bcd_acc[4*gi +: 4] >= 4'd5) ?
                                  bcd_acc[4*gi +: 4] + 4'd3 : bcd_acc[4*gi +: 4];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      bin_sr  <= '0;
      bcd_acc <= '0;
      cnt     <= '0;
      ovf_reg <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            bin_sr  <= value;
            bcd_acc <= '0;
            cnt     <= '0;
            if (value > BIN_W'(MAX_VAL)) begin
              ovf_reg <= 1'b1;
              state   <= ST_DONE;
            end else begin
              ovf_reg <= 1'b0;
              state   <= ST_SHIFT;
            end
          end
        end
        ST_SHIFT: begin
          bcd_acc <= {bcd_adj[BCD_W-2:0], bin_sr[BIN_W-1]};
          bin_sr  <= bin_sr << 1;
          cnt     <= cnt + 1'b1;
          if (cnt == CNT_W'(BIN_W - 1)) state <= ST_DONE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy     = (state != ST_IDLE);
  assign done     = (state == ST_DONE);
  assign overflow = ovf_reg;
  assign bcd      = bcd_acc;

endmodule

// File: rtl/seg7_scan_driver.sv
// Eight-digit scanned display driver: buffers converted BCD, commits it on the
// 7->0 scan wrap, and decodes the selected digit into registered pin levels.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int BIN_W      = 27,
  parameter int DIGITS     = 8,
  parameter bit ACTIVE_LOW = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        dig_id,
  input  logic [BIN_W-1:0]  value_bin,
  input  logic              value_valid,
  input  logic [DIGITS-1:0] dp_mask,
  input  logic              blank_lz,
  output logic [DIGITS-1:0] an,
  output logic [6:0]        seg,
  output logic              dp,
  output logic              busy,
  output logic              frame_sync
);

  localparam logic POL = ACTIVE_LOW;

  logic [BIN_W-1:0]  req_val;
  logic              req_full;
  logic [BCD_W-1:0]  pend_buf;
  logic              pend_ovf;
  logic              pend_full;
  logic [BCD_W-1:0]  disp_buf;
  logic              disp_ovf;
  logic [2:0]        prev_dig;

  logic              conv_start;
  logic [BIN_W-1:0]  conv_value;
  logic              conv_done;
  logic              conv_ovf;
  logic [BCD_W-1:0]  conv_bcd;
  logic              boundary;
  logic [DIGITS-1:0] zero_above;
  logic              blank_dig;
  logic [3:0]        nib;
  logic [6:0]        glyph_hi;

  // A parked request always wins the idle slot over a fresh strobe.
  assign conv_start = !busy && (req_full || value_valid);
  assign conv_value = req_full ? req_val : value_bin;

  bin2bcd_seq #(.BIN_W(BIN_W)) u_conv (
    .clk      (clk),
    .rst      (rst),
    .start    (conv_start),
    .value    (conv_value),
    .busy     (busy),
    .done     (conv_done),
    .overflow (conv_ovf),
    .bcd      (conv_bcd)
  );

  assign boundary   = (dig_id == 3'd0) && (prev_dig == 3'd7);
  assign frame_sync = boundary && pend_full;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_val   <= '0;
      req_full  <= 1'b0;
      pend_buf  <= '0;
      pend_ovf  <= 1'b0;
      pend_full <= 1'b0;
      disp_buf  <= '0;
      disp_ovf  <= 1'b0;
      prev_dig  <= 3'd0;
    end else begin
      prev_dig <= dig_id;
      if (value_valid && (busy || req_full)) begin
        req_val  <= value_bin;
        req_full <= 1'b1;
      end else if (!busy && req_full) begin
        req_full <= 1'b0;
      end
      if (frame_sync) begin
        disp_buf  <= pend_buf;
        disp_ovf  <= pend_ovf;
        pend_full <= 1'b0;
      end
      // A result landing on the boundary cycle waits for the next wrap.
      if (conv_done) begin
        pend_buf  <= conv_bcd;
        pend_ovf  <= conv_ovf;
        pend_full <= 1'b1;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_lz
      assign zero_above[gi] = (disp_buf[BCD_W-1:4*gi] == '0);
    end
  endgenerate

  assign nib       = disp_buf[4*dig_id +: 4];
  assign blank_dig = blank_lz && !disp_ovf && (dig_id != 3'd0) && zero_above[dig_id];
  assign glyph_hi  = disp_ovf ? GLYPH_DASH : (blank_dig ? GLYPH_BLANK : glyph(nib));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      an  <= {DIGITS{POL}};
      seg <= {7{POL}};
      dp  <= POL;
    end else begin
      an  <= (DIGITS'(1) << dig_id) ^ {DIGITS{POL}};
      seg <= glyph_hi ^ {7{POL}};
      dp  <= dp_mask[dig_id] ^ POL;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver: conversion timing, frame commit,
// blanking, overflow, request buffering and mid-conversion reset.
module tb_seg7_scan_driver;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [2:0]  dig_id = 3'd0;
  logic [26:0] value_bin = '0;
  logic        value_valid = 1'b0;
  logic [7:0]  dp_mask = 8'h00;
  logic        blank_lz = 1'b0;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        busy;
  logic        frame_sync;

  int vectors = 0;
  int miscompares = 0;

  // Active-low glyphs for 0..9, dash and blank.
  logic [6:0] lg [10];
  localparam logic [6:0] L_DASH  = 7'h3F;
  localparam logic [6:0] L_BLANK = 7'h7F;

  always #5 clk = ~clk;

  seg7_scan_driver dut (
    .clk         (clk),
    .rst         (rst),
    .dig_id      (dig_id),
    .value_bin   (value_bin),
    .value_valid (value_valid),
    .dp_mask     (dp_mask),
    .blank_lz    (blank_lz),
    .an          (an),
    .seg         (seg),
    .dp          (dp),
    .busy        (busy),
    .frame_sync  (frame_sync)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [26:0] v);
    value_bin   = v;
    value_valid = 1'b1;
    tick();
    value_valid = 1'b0;
  endtask

  task automatic show(input int d);
    dig_id = 3'(d);
    tick();
  endtask

  task automatic run_frame(output bit synced);
    for (int d = 1; d < 8; d++) begin
      dig_id = 3'(d);
      tick();
    end
    dig_id = 3'd0;
    #1;
    synced = frame_sync;
    tick();
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 200) begin
      n++;
      tick();
    end
  endtask

  task automatic test_reset();
    logic [7:0] exp_an;
    for (int d = 0; d < 4; d++) begin
      show(d);
      vectors++;
      if (an !== 8'hFF || seg !== 7'h7F || dp !== 1'b1 || busy !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_state: an=%h seg=%h dp=%b busy=%b expected an=ff seg=7f dp=1 busy=0",
                 an, seg, dp, busy);
      end
    end
    rst = 1'b1;
    tick();
    for (int d = 0; d < 8; d++) begin
      show(d);
      exp_an = ~(8'h01 << d);
      vectors++;
      if (seg !== lg[0] || an !== exp_an || dp !== 1'b1) begin
        miscompares++;
        $display("FAIL reset_zero_digit%0d: seg=%h an=%h dp=%b expected seg=%h an=%h dp=1",
                 d, seg, an, dp, lg[0], exp_an);
      end
    end
  endtask

  task automatic test_conversion();
    int n;
    bit s;
    logic [7:0] exp_an;
    dig_id = 3'd3;
    tick();
    strobe(27'd12_345_678);
    wait_idle(n);
    vectors++;
    if (n !== 28) begin
      miscompares++;
      $display("FAIL conv_busy_len: got %0d expected 28", n);
    end
    run_frame(s);
    vectors++;
    if (s !== 1'b1) begin
      miscompares++;
      $display("FAIL conv_frame_sync: got %b expected 1", s);
    end
    for (int d = 0; d < 8; d++) begin
      show(d);
      exp_an = ~(8'h01 << d);
      vectors++;
      if (seg !== lg[8-d] || an !== exp_an) begin
        miscompares++;
        $display("FAIL conv_digit%0d: seg=%h an=%h expected seg=%h an=%h",
                 d, seg, an, lg[8-d], exp_an);
      end
    end
  endtask

  task automatic test_blanking();
    int n;
    bit s;
    logic [6:0] exp_seg;
    logic [7:0] exp_an;
    logic       exp_dp;
    blank_lz = 1'b1;
    dp_mask  = 8'h04;
    dig_id   = 3'd3;
    strobe(27'd42);
    wait_idle(n);
    vectors++;
    if (n !== 28) begin
      miscompares++;
      $display("FAIL blank_busy_len: got %0d expected 28", n);
    end
    run_frame(s);
    vectors++;
    if (s !== 1'b1) begin
      miscompares++;
      $display("FAIL blank_frame_sync: got %b expected 1", s);
    end
    for (int d = 0; d < 8; d++) begin
      show(d);
      exp_seg = (d == 0) ? lg[2] : (d == 1) ? lg[4] : L_BLANK;
      exp_an  = ~(8'h01 << d);
      exp_dp  = (d == 2) ? 1'b0 : 1'b1;
      vectors++;
      if (seg !== exp_seg || an !== exp_an || dp !== exp_dp) begin
        miscompares++;
        $display("FAIL blank_digit%0d: seg=%h an=%h dp=%b expected seg=%h an=%h dp=%b",
                 d, seg, an, dp, exp_seg, exp_an, exp_dp);
      end
    end
    dp_mask = 8'h00;
  endtask

  task automatic test_overflow();
    int n;
    bit s;
    blank_lz = 1'b1;
    dig_id   = 3'd3;
    strobe(27'd100_000_000);
    wait_idle(n);
    vectors++;
    if (n !== 1) begin
      miscompares++;
      $display("FAIL ovf_busy_len: got %0d expected 1", n);
    end
    run_frame(s);
    vectors++;
    if (s !== 1'b1) begin
      miscompares++;
      $display("FAIL ovf_frame_sync: got %b expected 1", s);
    end
    for (int d = 0; d < 8; d++) begin
      show(d);
      vectors++;
      if (seg !== L_DASH) begin
        miscompares++;
        $display("FAIL ovf_digit%0d: seg=%h expected %h", d, seg, L_DASH);
      end
    end
  endtask

  task automatic test_back_to_back();
    int n;
    bit s;
    blank_lz = 1'b1;
    dig_id   = 3'd3;
    tick();
    value_valid = 1'b1;
    value_bin = 27'd5; tick();
    value_bin = 27'd6; tick();
    value_bin = 27'd7; tick();
    value_valid = 1'b0;
    wait_idle(n);
    vectors++;
    if (n !== 26) begin
      miscompares++;
      $display("FAIL b2b_first_len: got %0d expected 26", n);
    end
    tick();
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_second_start: busy=%b expected 1", busy);
    end
    run_frame(s);
    show(0);
    vectors++;
    if (s !== 1'b1 || seg !== lg[5]) begin
      miscompares++;
      $display("FAIL b2b_first_value: sync=%b seg=%h expected sync=1 seg=%h", s, seg, lg[5]);
    end
    show(1);
    vectors++;
    if (seg !== L_BLANK) begin
      miscompares++;
      $display("FAIL b2b_first_lz: seg=%h expected %h", seg, L_BLANK);
    end
    wait_idle(n);
    run_frame(s);
    show(0);
    vectors++;
    if (s !== 1'b1 || seg !== lg[7]) begin
      miscompares++;
      $display("FAIL b2b_second_value: sync=%b seg=%h expected sync=1 seg=%h", s, seg, lg[7]);
    end
    tick();
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_no_third: busy=%b expected 0", busy);
    end
  endtask

  task automatic test_reset_mid_shift();
    bit s;
    blank_lz = 1'b0;
    dig_id   = 3'd3;
    strobe(27'd12_345_678);
    repeat (10) tick();
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_mid_pre_busy: busy=%b expected 1", busy);
    end
    rst = 1'b0;
    #1;
    vectors++;
    if (busy !== 1'b0 || an !== 8'hFF || seg !== 7'h7F || dp !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_mid_async: busy=%b an=%h seg=%h dp=%b expected busy=0 an=ff seg=7f dp=1",
               busy, an, seg, dp);
    end
    tick();
    rst = 1'b1;
    tick();
    run_frame(s);
    vectors++;
    if (s !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_mid_no_sync: got %b expected 0", s);
    end
    repeat (30) tick();
    run_frame(s);
    vectors++;
    if (s !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_mid_quiet: sync=%b busy=%b expected 0 0", s, busy);
    end
    show(0);
    vectors++;
    if (seg !== lg[0]) begin
      miscompares++;
      $display("FAIL rst_mid_digit0: seg=%h expected %h", seg, lg[0]);
    end
    show(7);
    vectors++;
    if (seg !== lg[0]) begin
      miscompares++;
      $display("FAIL rst_mid_digit7: seg=%h expected %h", seg, lg[0]);
    end
  endtask

  initial begin
    lg[0] = 7'h40; lg[1] = 7'h79; lg[2] = 7'h24; lg[3] = 7'h30; lg[4] = 7'h19;
    lg[5] = 7'h12; lg[6] = 7'h02; lg[7] = 7'h78; lg[8] = 7'h00; lg[9] = 7'h10;
    test_reset();
    test_conversion();
    test_blanking();
    test_overflow();
    test_back_to_back();
    test_reset_mid_shift();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Downstream consumer of the 3-bit scan index from the digit-scan counter; drives the 8-digit seven-segment display of the game board.
- Converts a binary score/value to 8 BCD digits with a sequential double-dabble engine, double-buffers the result, and commits it only at a frame boundary to prevent tearing.
- Decodes the digit currently selected by the scan index into registered anode, segment and decimal-point outputs.

Parameters:
- BIN_W, 27, width of the binary input; 2^27 > 99_999_999.
- DIGITS, 8, digit count; fixed to match the 3-bit scan index.
- ACTIVE_LOW, 1, polarity of an/seg/dp; 1 means a low level lights the element.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- dig_id  in  3  current scan index 0..7 from the scan counter
- value_bin  in  BIN_W  binary value to display
- value_valid  in  1  one-cycle strobe; captures value_bin
- dp_mask  in  8  per-digit decimal point, bit i = digit i; sampled live, not buffered
- blank_lz  in  1  enable leading-zero blanking
- an  out  8  digit anodes, one-hot per ACTIVE_LOW
- seg  out  7  segments {g,f,e,d,c,b,a}
- dp  out  1  decimal point of the selected digit
- busy  out  1  conversion in progress
- frame_sync  out  1  one-cycle pulse when the pending buffer is committed

Behaviour:
- Reset is asynchronous, active-low on rst; clock is clk.
- Reset values:
  - an = 8'hFF, seg = 7'h7F, dp = 1 (all dark, ACTIVE_LOW = 1).
  - busy = 0, frame_sync = 0.
  - Pending and display buffers = 0; overflow flags clear; request buffer empty.
- Converter FSM, states IDLE, SHIFT, DONE:
  - IDLE: value_valid = 1 captures value_bin, clears the BCD accumulator, sets busy, goes to SHIFT.
  - SHIFT: runs BIN_W iterations, one per cycle. Each iteration adds 3 to every BCD nibble >= 5, then shifts left 1, shifting in the binary MSB.
  - DONE (1 cycle): writes the 32-bit BCD result to the pending buffer, sets pending_full, clears busy, returns to IDLE.
  - busy is high from the cycle after value_valid through the DONE cycle, i.e. BIN_W+1 cycles.
- Overflow: a captured value > 99_999_999 skips conversion (SHIFT lasts 0 cycles), goes straight to DONE and sets pending_ovf. A committed overflow displays '-' on all 8 digits.
- Request buffer (one deep):
  - value_valid while busy stores value_bin in the request buffer; a newer strobe overwrites the older one.
  - After DONE, a buffered request starts the next conversion in the following cycle.
  - value_valid in the same cycle as DONE goes to the request buffer.
- Frame commit:
  - Frame boundary = dig_id == 0 while the registered previous dig_id == 7.
  - At the boundary with pending_full = 1: pending buffer and pending_ovf copy into the display buffer, pending_full clears, frame_sync pulses in that cycle.
  - No pending data at the boundary: no commit, no pulse.
  - Pending written by DONE in the same cycle as the boundary commits at the next boundary.
- Glyph decode:
  - Digit d = dig_id. Nibble 0..9 maps to standard glyphs; 0xA..0xF cannot occur.
  - Leading-zero blank: digit d (d != 0) is dark when blank_lz = 1, ovf = 0, and display nibbles d..7 are all zero. Digit 0 is never blanked.
  - dp = dp_mask[dig_id], inverted per ACTIVE_LOW. Blanking does not suppress dp.
- Output latency: an/seg/dp are registered 1 cycle after dig_id. an = ~(1 << dig_id) when ACTIVE_LOW.
- Reset mid-conversion aborts the conversion, clears all buffers, and returns outputs to reset values immediately.

Decomposition:
- seg7_pkg holds:
  - glyph constants GLYPH_0..GLYPH_9, GLYPH_DASH = 7'b1000000 (active-high g), GLYPH_BLANK;
  - NUM_DIGITS = 8, BCD_W = 32, MAX_VAL = 99_999_999;
  - FSM state encoding.
- One sub-module, bin2bcd_seq: the double-dabble engine with start/busy/done/overflow ports.
- Buffers, commit logic and decode stay in seg7_scan_driver.

Test Plan:
- Reset: rst low with dig_id cycling -> an = 8'hFF, seg = 7'h7F, dp = 1, busy = 0. After release with blank_lz = 0, every digit shows GLYPH_0 active-low.
- Conversion: value_valid with value_bin = 12_345_678 -> busy high exactly 28 cycles. frame_sync at the next 7->0 of dig_id. Then dig_id = 0 gives seg for '8' and dig_id = 7 gives seg for '1'.
- Blanking: value_bin = 42, blank_lz = 1 -> digits 0/1 show '2'/'4', digits 2..7 dark (seg = 7'h7F), with an still asserted.
- Overflow: value_bin = 100_000_000 -> busy high 1 cycle; after commit all digits show active-low '-'. blank_lz has no effect.
- Back-to-back: strobes of 5, 6, 7 within 3 cycles -> 5 converts and 7 converts next (6 is dropped). Display shows 7 once it is committed.
- Reset mid-SHIFT: rst asserted 10 cycles into a conversion -> busy = 0 immediately. No frame_sync follows, and the display stays at 0.
